// File: rtl/cpu_pkg.sv
// Shared definitions for the five-way demultiplexing buffer: state encoding,
// destination count and the select type.
package cpu_pkg;

    localparam int NUM_DEST = 5;

    typedef logic [2:0] sel_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/sel_dec5.sv
// Decodes a 3-bit destination select into a 5-bit one-hot vector and flags
// selects 5-7, which address no destination.
module sel_dec5
    import cpu_pkg::*;
(
    input  logic [2:0]          i_sel,
    output logic [NUM_DEST-1:0] o_onehot,
    output logic                o_illegal
);

    generate
        for (genvar gi = 0; gi < NUM_DEST; gi++) begin : g_dec
            assign o_onehot[gi] = (i_sel == 3'(gi));
        end
    endgenerate

    assign o_illegal = (i_sel >= 3'(NUM_DEST));

endmodule

// File: rtl/demux5_buf.sv
// Two-entry (head + skid) buffer that routes each word to one of five
// destinations in arrival order. Define DEMUX5_ERR_EN to add err/err_cnt.
module demux5_buf
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_valid,
    input  logic [4:0]       out_ready
`ifdef DEMUX5_ERR_EN
    ,
    output logic             err,
    output logic [7:0]       err_cnt
`endif
);

    state_t             r_state;
    logic               r_in_ready;
    logic [WIDTH-1:0]   r_head_data;
    logic [4:0]         r_head_oh;
    logic [WIDTH-1:0]   r_skid_data;
    logic [4:0]         r_skid_oh;

    logic [4:0]         w_sel_oh;
    logic               w_illegal;
    logic               w_push;
    logic               w_lpush;
    logic               w_pop;

    state_t             w_state_next;
    logic [WIDTH-1:0]   w_head_data_next;
    logic [4:0]         w_head_oh_next;
    logic [WIDTH-1:0]   w_skid_data_next;
    logic [4:0]         w_skid_oh_next;

    sel_dec5 u_sel_dec5 (
        .i_sel     (in_sel),
        .o_onehot  (w_sel_oh),
        .o_illegal (w_illegal)
    );

    assign w_push  = in_valid & r_in_ready;
    assign w_lpush = w_push & ~w_illegal;
    // Only the destination the head is addressed to can complete a pop.
    assign w_pop   = |(r_head_oh & out_ready);

    always_comb begin
        w_state_next     = r_state;
        w_head_data_next = r_head_data;
        w_head_oh_next   = r_head_oh;
        w_skid_data_next = r_skid_data;
        w_skid_oh_next   = r_skid_oh;
        case (r_state)
            ST_EMPTY: begin
                if (w_lpush) begin
                    w_state_next     = ST_ONE;
                    w_head_data_next = in_data;
                    w_head_oh_next   = w_sel_oh;
                end
            end
            ST_ONE: begin
                if (w_lpush && w_pop) begin
                    w_head_data_next = in_data;
                    w_head_oh_next   = w_sel_oh;
                end else if (w_lpush) begin
                    w_state_next     = ST_FULL;
                    w_skid_data_next = in_data;
                    w_skid_oh_next   = w_sel_oh;
                end else if (w_pop) begin
                    w_state_next     = ST_EMPTY;
                    w_head_data_next = '0;
                    w_head_oh_next   = '0;
                end
            end
            ST_FULL: begin
                if (w_pop) begin
                    w_state_next     = ST_ONE;
                    w_head_data_next = r_skid_data;
                    w_head_oh_next   = r_skid_oh;
                    w_skid_data_next = '0;
                    w_skid_oh_next   = '0;
                end
            end
            default: begin
                w_state_next     = ST_EMPTY;
                w_head_data_next = '0;
                w_head_oh_next   = '0;
                w_skid_data_next = '0;
                w_skid_oh_next   = '0;
            end
        endcase
    end

    // in_ready is a registered decode of the next state, never a path from out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_head_data <= '0;
            r_head_oh   <= '0;
            r_skid_data <= '0;
            r_skid_oh   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next != ST_FULL);
            r_head_data <= w_head_data_next;
            r_head_oh   <= w_head_oh_next;
            r_skid_data <= w_skid_data_next;
            r_skid_oh   <= w_skid_oh_next;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_head_data;
    assign out_valid = r_head_oh;

`ifdef DEMUX5_ERR_EN
    logic       r_err;
    logic [7:0] r_err_cnt;
    logic       w_ipush;

    assign w_ipush = w_push & w_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else begin
            r_err <= w_ipush;
            if (w_ipush && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    assign err     = r_err;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_demux5_buf.sv
// Self-checking bench for demux5_buf: directed scenarios plus randomized traffic
// against a queue-based reference model. Honours DEMUX5_ERR_EN.
module tb_demux5_buf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic [2:0]  in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic [4:0]  out_valid;
    logic [4:0]  out_ready;
`ifdef DEMUX5_ERR_EN
    logic        err;
    logic [7:0]  err_cnt;
`endif

    always #5 clk = ~clk;

    demux5_buf #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX5_ERR_EN
        ,
        .err       (err),
        .err_cnt   (err_cnt)
`endif
    );

    typedef struct {
        logic [15:0] data;
        logic [2:0]  sel;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] exp_pops[$];
    logic [15:0] dut_pops[$];
    bit          m_ready;
    bit          m_err;
    int          m_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    function automatic logic [4:0] m_valid();
        logic [4:0] one = 5'd1;
        if (mq.size() == 0) return 5'd0;
        return one << mq[0].sel;
    endfunction

    function automatic logic [15:0] m_data();
        if (mq.size() == 0) return 16'd0;
        return mq[0].data;
    endfunction

    // Advance one clock, updating the model from the handshakes at that edge.
    task automatic cycle();
        bit push;
        bit pop;
        push = in_valid && m_ready;
        pop  = (mq.size() > 0) && out_ready[mq[0].sel];
        if ((out_valid & out_ready) != 5'd0) dut_pops.push_back(out_data);
        @(posedge clk);
        if (pop) begin
            exp_pops.push_back(mq[0].data);
            void'(mq.pop_front());
        end
        m_err = 1'b0;
        if (push) begin
            if (in_sel < 3'd5) begin
                mq.push_back('{in_data, in_sel});
            end else begin
                m_err = 1'b1;
                if (m_cnt < 255) m_cnt++;
            end
        end
        m_ready = (mq.size() < 2);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        mq.delete();
        exp_pops.delete();
        dut_pops.delete();
        m_ready = 1'b0;
        m_err   = 1'b0;
        m_cnt   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = '0;
        #1;
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_tests++;
        if (out_valid !== 5'd0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 00000", out_valid); end
        n_tests++;
        if (out_data !== 16'd0) begin n_fail++; $display("FAIL reset_out_data: got %h expected 0000", out_data); end
`ifdef DEMUX5_ERR_EN
        n_tests++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %b/%0d expected 0/0", err, err_cnt); end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready: got %b expected 1", in_ready); end
        $display("[TB] reset: in_ready=%b out_valid=%b", in_ready, out_valid);
    endtask

    task automatic test_single();
        do_reset();
        in_valid = 1'b1; in_data = 16'hABCD; in_sel = 3'd0; out_ready = 5'b11111;
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 5'b00001 || out_valid !== m_valid()) begin n_fail++; $display("FAIL single_valid: got %b expected 00001", out_valid); end
        n_tests++;
        if (out_data !== 16'hABCD) begin n_fail++; $display("FAIL single_data: got %h expected abcd", out_data); end
        cycle();
        n_tests++;
        if (out_valid !== 5'd0 || out_data !== 16'd0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_empty: got %b/%h/%b expected 00000/0000/1", out_valid, out_data, in_ready);
        end
        $display("[TB] single: pushed abcd sel0, popped next cycle");
    endtask

    task automatic test_order();
        logic [15:0] want[3];
        bit acc;
        want[0] = 16'h0123; want[1] = 16'h4567; want[2] = 16'h89EF;
        do_reset();
        out_ready = 5'd0;
        in_valid = 1'b1; in_data = 16'h0123; in_sel = 3'd1;
        cycle();
        in_data = 16'h4567; in_sel = 3'd3;
        cycle();
        n_tests++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL order_full_in_ready: got %b expected 0", in_ready); end
        in_data = 16'h89EF; in_sel = 3'd4;
        repeat (3) begin
            cycle();
            n_tests++;
            if (in_ready !== 1'b0 || out_data !== 16'h0123 || out_valid !== 5'b00010) begin
                n_fail++; $display("FAIL order_hold: got %b/%h/%b expected 0/0123/00010", in_ready, out_data, out_valid);
            end
        end
        out_ready = 5'b11111;
        for (int i = 0; i < 8; i++) begin
            acc = in_valid && m_ready;
            cycle();
            if (acc) in_valid = 1'b0;
        end
        n_tests++;
        if (dut_pops.size() != 3) begin
            n_fail++; $display("FAIL order_count: got %0d expected 3", dut_pops.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (dut_pops[i] !== want[i] || dut_pops[i] !== exp_pops[i]) begin
                    n_fail++; $display("FAIL order_word%0d: got %h expected %h", i, dut_pops[i], want[i]);
                end
            end
        end
        $display("[TB] order: %0d words delivered", dut_pops.size());
    endtask

    task automatic test_push_pop();
        do_reset();
        out_ready = 5'd0;
        in_valid = 1'b1; in_data = 16'hAAAA; in_sel = 3'd2;
        cycle();
        in_data = 16'h5555; in_sel = 3'd0; out_ready = 5'b00100;
        cycle();
        in_valid = 1'b0; out_ready = 5'd0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 5'b00001 || out_data !== 16'h5555) begin
            n_fail++; $display("FAIL push_pop: got %b/%b/%h expected 1/00001/5555", in_ready, out_valid, out_data);
        end
        out_ready = 5'b11111;
        cycle();
        $display("[TB] push_pop: head=%h after simultaneous push/pop", 16'h5555);
    endtask

    task automatic test_illegal();
        do_reset();
        out_ready = 5'b11111;
        in_valid = 1'b1; in_data = 16'h1111; in_sel = 3'b101;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL illegal_ready: got %b expected 1", in_ready); end
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 5'd0) begin n_fail++; $display("FAIL illegal_no_valid: got %b expected 00000", out_valid); end
`ifdef DEMUX5_ERR_EN
        n_tests++;
        if (err !== 1'b1 || err_cnt !== 8'd1) begin n_fail++; $display("FAIL illegal_err: got %b/%0d expected 1/1", err, err_cnt); end
`endif
        cycle();
        n_tests++;
        if (out_valid !== 5'd0) begin n_fail++; $display("FAIL illegal_no_valid2: got %b expected 00000", out_valid); end
`ifdef DEMUX5_ERR_EN
        n_tests++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_err_pulse: got %b expected 0", err); end
        in_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            in_sel = 3'($urandom_range(5, 7));
            cycle();
        end
        in_valid = 1'b0;
        n_tests++;
        if (err_cnt !== 8'd255 || int'(err_cnt) != m_cnt) begin n_fail++; $display("FAIL illegal_sat: got %0d expected 255", err_cnt); end
`endif
        $display("[TB] illegal: sel 5 dropped, out_valid=%b", out_valid);
    endtask

    task automatic test_reset_full();
        do_reset();
        out_ready = 5'd0;
        in_valid = 1'b1; in_data = 16'hC001; in_sel = 3'd2;
        cycle();
        in_data = 16'hC002; in_sel = 3'd3;
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 5'b00100) begin n_fail++; $display("FAIL rfull_setup: got %b/%b expected 0/00100", in_ready, out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete(); m_ready = 1'b0; m_cnt = 0;
        n_tests++;
        if (out_valid !== 5'd0 || out_data !== 16'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL rfull_async: got %b/%h/%b expected 00000/0000/0", out_valid, out_data, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b1;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 5'd0) begin n_fail++; $display("FAIL rfull_release: got %b/%b expected 1/00000", in_ready, out_valid); end
        $display("[TB] reset_full: buffer flushed");
    endtask

    task automatic test_stall();
        do_reset();
        out_ready = 5'd0;
        in_valid = 1'b1; in_data = 16'hBEEF; in_sel = 3'd4;
        cycle();
        in_valid = 1'b0; out_ready = 5'b01111;
        for (int i = 0; i < 6; i++) begin
            cycle();
            n_tests++;
            if (out_data !== 16'hBEEF || out_valid !== 5'b10000) begin
                n_fail++; $display("FAIL stall_hold%0d: got %h/%b expected beef/10000", i, out_data, out_valid);
            end
        end
        out_ready = 5'b11111;
        cycle();
        n_tests++;
        if (out_valid !== 5'd0) begin n_fail++; $display("FAIL stall_release: got %b expected 00000", out_valid); end
        $display("[TB] stall: head held 6 cycles then popped");
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 16'($urandom);
            in_sel    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            out_ready = 5'($urandom);
            cycle();
            n_tests++;
            if (out_valid !== m_valid() || out_data !== m_data() || in_ready !== m_ready) begin
                n_fail++;
                $display("FAIL random%0d: got %b/%h/%b expected %b/%h/%b", i, out_valid, out_data, in_ready, m_valid(), m_data(), m_ready);
            end
`ifdef DEMUX5_ERR_EN
            n_tests++;
            if (err !== m_err || int'(err_cnt) != m_cnt) begin
                n_fail++; $display("FAIL random_err%0d: got %b/%0d expected %b/%0d", i, err, err_cnt, m_err, m_cnt);
            end
`endif
        end
        in_valid = 1'b0;
        n_tests++;
        if (dut_pops.size() != exp_pops.size()) begin
            n_fail++; $display("FAIL random_pops: got %0d expected %0d", dut_pops.size(), exp_pops.size());
        end
        $display("[TB] random: 500 cycles, %0d pops", exp_pops.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_order();
        test_push_pop();
        test_illegal();
        test_reset_full();
        test_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/demux5_buf.md
DEMUX5_BUF -- requirements
Module: demux5_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the data word width.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH bits: the word to route.
REQ-005 SHALL have port in_sel, input, 3 bits: the destination index; 0-4 are legal.
REQ-006 SHALL have port in_valid, input, 1 bit: the producer offers in_data/in_sel.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-008 SHALL have port out_data, output, WIDTH bits: the head-entry word, shared by all destinations.
REQ-009 SHALL have port out_valid, output, 5 bits: one-hot; bit k means the head is for destination k.
REQ-010 SHALL have port out_ready, input, 5 bits: bit k means destination k accepts the word.

Function
REQ-011 SHALL transfer an input word when in_valid and in_ready are both 1 at a rising clk edge (push).
REQ-012 SHALL complete a pop when out_valid[k] and out_ready[k] are both 1 at a rising clk edge; out_ready bits with no matching out_valid bit are ignored.
REQ-013 SHALL hold up to 2 entries (head + skid) in a state machine EMPTY / ONE / FULL:
- EMPTY: push goes to ONE.
- ONE: push only goes to FULL; pop only goes to EMPTY; push and pop together stay ONE with the new word at head.
- FULL: pop goes to ONE, with the skid entry promoted to head.
REQ-014 SHALL drive in_ready = 1 in EMPTY and ONE and 0 in FULL; in_ready SHALL be a registered state decode, not combinational from out_ready.
REQ-015 SHALL have a latency of one cycle: a word pushed into EMPTY appears on out_data/out_valid at the next edge.
REQ-016 SHALL drive out_valid = 0 when the block is EMPTY and exactly one bit when it is not; out_data SHALL be 0 when EMPTY.
REQ-017 SHALL preserve arrival order across all destinations; a stalled head SHALL block later words (no reordering).
REQ-018 SHALL keep out_data and out_valid stable while the head is not popped.
REQ-019 SHALL, for a push with in_sel of 5-7, accept the word (in_ready handshake completes) and then discard it; no entry is stored.

Reset
REQ-020 SHALL, while rst_n = 0, force EMPTY, in_ready = 0, out_valid = 0, out_data = 0, and with DEMUX5_ERR_EN also err = 0 and err_cnt = 0.
REQ-021 SHALL set in_ready = 1 on the first clk edge after rst_n deasserts.
REQ-022 SHALL discard all buffered words when reset is asserted mid-operation.

Configuration
REQ-023 SHALL, with macro DEMUX5_ERR_EN defined, add outputs err (1 bit) and err_cnt (8 bits):
- err pulses for one cycle after each accepted illegal-sel push.
- err_cnt increments on each such push and saturates at 255.
REQ-024 SHALL, without DEMUX5_ERR_EN, omit these ports; illegal words are dropped silently.

Structure
REQ-025 SHALL place the state encoding (EMPTY=0, ONE=1, FULL=2), the constant NUM_DEST=5 and the 3-bit sel typedef in shared package cpu_pkg.
REQ-026 SHALL use one sub-module, sel_dec5, to decode 3-bit sel to 5-bit one-hot plus an illegal flag.

Verification
REQ-027 Bench SHALL cover these directed scenarios:
- After reset, push 16'hABCD with sel = 0 and out_ready = 5'b11111: out_valid = 5'b00001, out_data = ABCD one cycle later, then EMPTY.
- Hold out_ready = 0; push 0123 (sel 1), 4567 (sel 3), 89EF (sel 4): in_ready = 0 after the second push, and the third push is held. Release out_ready = 5'b11111: outputs appear in order 0123, 4567, 89EF.
- In ONE with head sel 2, push and pop in the same cycle: state stays ONE and the new word is at head on the next edge.
- Push with sel = 3'b101: handshake completes and no out_valid follows; with DEMUX5_ERR_EN, err = 1 for one cycle and err_cnt = 1; 300 illegal pushes give err_cnt = 255.
- Assert rst_n low while FULL: out_valid = 0 and out_data = 0 immediately (asynchronously); in_ready = 1 on the first edge after release.
- Head sel 4 with out_ready = 5'b01111: no pop; out_data is held stable for at least 5 cycles.
